// File: rtl/gen_burst_ctrl_if.sv
// rtl/gen_burst_ctrl_if.sv - configuration, generator and output-stream bundle for gen_burst_ctrl
interface gen_burst_ctrl_if #(
    parameter int DATA_SIZE = 32,
    parameter int LEN_W     = 8,
    parameter int CNT_W     = 8,
    parameter int GAP_W     = 8
);
    logic                     cfg_start;
    logic                     cfg_stop;
    logic [LEN_W-1:0]         cfg_len;
    logic [CNT_W-1:0]         cfg_bursts;
    logic [GAP_W-1:0]         cfg_gap;

    logic                     gen_enable;
    logic                     gen_tready;
    logic [DATA_SIZE-1:0]     gen_tdata;
    logic                     gen_tvalid;

    logic [DATA_SIZE-1:0]     m_axis_tdata;
    logic [DATA_SIZE/8-1:0]   m_axis_tstrb;
    logic                     m_axis_tvalid;
    logic                     m_axis_tlast;
    logic                     m_axis_tready;

    logic                     busy;
    logic                     done;
    logic [CNT_W-1:0]         burst_cnt;

    modport master (
        input  cfg_start, cfg_stop, cfg_len, cfg_bursts, cfg_gap,
        output gen_enable, gen_tready,
        input  gen_tdata, gen_tvalid,
        output m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output busy, done, burst_cnt
    );

    modport slave (
        output cfg_start, cfg_stop, cfg_len, cfg_bursts, cfg_gap,
        input  gen_enable, gen_tready,
        output gen_tdata, gen_tvalid,
        input  m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  busy, done, burst_cnt
    );
endinterface

// File: rtl/gen_burst_ctrl.sv
// rtl/gen_burst_ctrl.sv - burst sequencer framing power-of-3 generator beats into fixed-length packets
module gen_burst_ctrl #(
    parameter int DATA_SIZE = 32,
    parameter int LEN_W     = 8,
    parameter int CNT_W     = 8,
    parameter int GAP_W     = 8
) (
    input  logic             aclk,
    input  logic             areset,
    gen_burst_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_GAP} state_t;

    state_t               state_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     issued_q;
    logic [LEN_W-1:0]     captured_q;
    logic [CNT_W-1:0]     bursts_q;
    logic [CNT_W-1:0]     burst_cnt_q;
    logic [GAP_W-1:0]     gap_q;
    logic [GAP_W-1:0]     gap_cnt_q;
    logic                 stop_q;
    logic                 done_q;
    logic                 inflight_q;
    logic [1:0]           occ_q;
    logic [DATA_SIZE-1:0] head_data_q;
    logic [DATA_SIZE-1:0] tail_data_q;
    logic                 head_last_q;
    logic                 tail_last_q;

    logic                 m_valid;
    logic                 pop;
    logic                 push;
    logic                 push_last;
    logic                 gen_en;
    logic [2:0]           credit;
    logic [2:0]           credit_limit;

    assign m_valid   = (occ_q != 2'd0);
    assign pop       = m_valid && bus.m_axis_tready;
    assign push      = bus.gen_tvalid && inflight_q;
    assign push_last = (captured_q == len_q - LEN_W'(1));

    // Request enable stays combinational on the downstream pop so a
    // 2-entry buffer still sustains one beat per cycle under full ready.
    assign credit       = 3'(occ_q) + 3'(inflight_q);
    assign credit_limit = pop ? 3'd3 : 3'd2;
    assign gen_en       = (state_q == S_ISSUE) && (credit < credit_limit);

    assign bus.gen_enable    = gen_en;
    assign bus.gen_tready    = gen_en;
    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = head_data_q;
    assign bus.m_axis_tlast  = head_last_q && m_valid;
    assign bus.m_axis_tstrb  = {(DATA_SIZE/8){m_valid}};
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = done_q;
    assign bus.burst_cnt     = burst_cnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            head_data_q <= '0;
            tail_data_q <= '0;
            head_last_q <= 1'b0;
            tail_last_q <= 1'b0;
        end else begin
            inflight_q <= gen_en;
            unique case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_data_q <= bus.gen_tdata;
                        head_last_q <= push_last;
                    end else begin
                        tail_data_q <= bus.gen_tdata;
                        tail_last_q <= push_last;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_data_q <= tail_data_q;
                    head_last_q <= tail_last_q;
                    occ_q       <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_data_q <= bus.gen_tdata;
                        head_last_q <= push_last;
                    end else begin
                        head_data_q <= tail_data_q;
                        head_last_q <= tail_last_q;
                        tail_data_q <= bus.gen_tdata;
                        tail_last_q <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            bursts_q    <= '0;
            gap_q       <= '0;
            issued_q    <= '0;
            captured_q  <= '0;
            gap_cnt_q   <= '0;
            burst_cnt_q <= '0;
            stop_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push) begin
                captured_q <= captured_q + LEN_W'(1);
            end
            if ((state_q != S_IDLE) && bus.cfg_stop) begin
                stop_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cfg_start && (bus.cfg_len != '0)) begin
                        len_q       <= bus.cfg_len;
                        bursts_q    <= bus.cfg_bursts;
                        gap_q       <= bus.cfg_gap;
                        burst_cnt_q <= '0;
                        stop_q      <= 1'b0;
                        issued_q    <= '0;
                        captured_q  <= '0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (gen_en) begin
                        issued_q <= issued_q + LEN_W'(1);
                        if (issued_q == len_q - LEN_W'(1)) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (pop && head_last_q) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                        issued_q    <= '0;
                        captured_q  <= '0;
                        // A stop arriving on the closing handshake itself still ends here.
                        if (((bursts_q != '0) && (burst_cnt_q + CNT_W'(1) == bursts_q))
                            || stop_q || bus.cfg_stop) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else if (gap_q != '0) begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == gap_q - GAP_W'(1)) begin
                        state_q <= S_ISSUE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/gen_burst_ctrl.md
# gen_burst_ctrl

Burst sequencer for the power-of-3 AXI-Stream generator. It drives the generator's enable and ready inputs, captures the generator's beats into a 2-entry output buffer, and re-frames them as fixed-length packets on a master AXI-Stream port. The packets carry correct tvalid/tready backpressure and tlast framing. It sits between the generator and the downstream consumer, and software or a top-level FSM configures it.

## Interface
- DATA_SIZE, 32, stream data width; tstrb width is DATA_SIZE/8
- LEN_W, 8, width of the burst-length field
- CNT_W, 8, width of the burst-count field and the completed-burst counter
- GAP_W, 8, width of the inter-burst gap field

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle pulse; sampled only in IDLE
- cfg_stop  in  1  level or pulse; requests stop after the current burst
- cfg_len  in  LEN_W  beats per burst; 0 makes cfg_start ignored
- cfg_bursts  in  CNT_W  burst count; 0 = continuous until stop
- cfg_gap  in  GAP_W  idle cycles between bursts
- gen_enable  out  1  to generator m00_axis_enable
- gen_tready  out  1  to generator m00_axis_tready; always equal to gen_enable
- gen_tdata  in  DATA_SIZE  from generator
- gen_tvalid  in  1  from generator
- m_axis_tdata  out  DATA_SIZE  output data
- m_axis_tstrb  out  DATA_SIZE/8  all ones while tvalid, else 0
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last beat of a burst
- m_axis_tready  in  1  downstream ready
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the final burst completes
- burst_cnt  out  CNT_W  completed bursts since start; wraps

## Operation
- On cfg_start in IDLE with cfg_len != 0, latch cfg_len, cfg_bursts and cfg_gap, clear burst_cnt and any latched stop request, and go to ISSUE.
- cfg_start is ignored outside IDLE. Config inputs are ignored except at start.
- ISSUE state:
  - Assert gen_enable when occ + inflight − pop < 2, where:
    - occ = buffer entries (0..2)
    - inflight = gen_enable registered from the previous cycle
    - pop = m_axis_tvalid & m_axis_tready
  - Count issued requests. After cfg_len requests, go to FLUSH.
- Capture: on every gen_tvalid, write gen_tdata plus a last tag into the buffer. The tag is 1 when the captured-beat index equals cfg_len−1.
- Generator tstrb and tlast are not used.
- Buffer: 2-entry FIFO. Simultaneous push and pop are allowed. Overflow is impossible by construction. The bench asserts this.
- FLUSH state: wait until the tagged last beat is accepted. Then:
  - Increment burst_cnt.
  - If cfg_bursts != 0 and burst_cnt+1 == cfg_bursts, or a stop is latched: go to IDLE and pulse done.
  - Else, if cfg_gap != 0: go to GAP.
  - Else: go to ISSUE.
- GAP state: count cfg_gap cycles, then go to ISSUE. There is no gap after the final burst.
- cfg_stop is latched in any non-IDLE state. A burst in progress is never truncated.
- Generator data is not reset by this block. The value sequence continues across bursts and starts.
- Reset mid-operation: all state clears immediately and asynchronously. Buffered beats are discarded. A generator beat already in flight at release is dropped, because capture is enabled only when inflight = 1.

## Timing
- Reset values:
  - state IDLE
  - gen_enable 0
  - m_axis_tvalid 0, m_axis_tlast 0, m_axis_tstrb 0, m_axis_tdata 0
  - busy 0, done 0, burst_cnt 0
  - occ 0, inflight 0
- Start accepted at edge E0:
  - ISSUE and gen_enable = 1 in cycle 1.
  - Generator beat valid in cycle 2.
  - m_axis_tvalid in cycle 3.
  - Start-to-first-beat latency is 3 cycles.
- With m_axis_tready held high: one beat per cycle, no bubbles within a burst.
- m_axis_tvalid, tdata and tlast are registered, and hold stable while tvalid & !tready.
- done asserts in the cycle after the final tlast handshake. busy falls in the same cycle.
- The GAP interval is measured from the first cycle after the tlast handshake. Exactly cfg_gap cycles pass with gen_enable = 0 before ISSUE.
- burst_cnt updates on the edge of the tlast handshake.

## Test plan
- Single burst: generator freshly reset; cfg_len=4, cfg_bursts=1, cfg_gap=0, tready=1 → tdata 3, 9, 27, 81 on consecutive cycles 3..6. tlast only with 81. done in cycle 7. burst_cnt=1.
- Backpressure: cfg_len=8, tready random at 50% → exactly 8 handshakes, tdata 3..6561 in order, no duplicates or drops, occ never >2, tdata stable while stalled.
- Multi-burst with gap: cfg_len=2, cfg_bursts=3, cfg_gap=2 → three 2-beat packets, tlast on beats 2, 4 and 6. Exactly 2 gen_enable-low cycles after each non-final tlast. Single done pulse.
- Continuous mode with stop: cfg_bursts=0, cfg_len=5; pulse cfg_stop during beat 2 of burst 3 → burst 3 completes with 5 beats and tlast, then IDLE. done pulses once. burst_cnt=3.
- Illegal or ignored starts:
  - cfg_len=0 start → busy stays 0.
  - cfg_start while busy → no effect on counts or framing.
- Reset mid-burst: assert areset at beat 3 of 6 → all outputs at reset values within the same cycle, without a clock edge. A new start after release produces a correctly framed burst.
